// File: rtl/sdp00_line_writer_pkg.sv
// Shared constants and FSM encoding for the sdp00 line-buffer writer.
package sdp00_line_writer_pkg;

    localparam int SDP_DATA_W     = 32;
    localparam int SDP_ADDR_W     = 8;
    localparam int SDP_BANK_WORDS = 128;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DROP  = 2'd3
    } state_t;

endpackage

// File: rtl/sdp00_line_writer_pix_pack.sv
// Pixel packer: gathers PPW pixels little-endian into one 32-bit word.
// word_rdy is asserted combinationally on the cycle the last lane is filled;
// on flush, word presents the partial word with unused upper lanes at zero.
module sdp00_line_writer_pix_pack
    import sdp00_line_writer_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  clr,
    input  logic                  pix_en,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  flush,
    output logic                  word_rdy,
    output logic                  pending,
    output logic [SDP_DATA_W-1:0] word
);

    localparam int PPW = SDP_DATA_W / PIX_W;

    logic [SDP_DATA_W-1:0] lanes;
    logic [SDP_DATA_W-1:0] merged;
    logic [2:0]            cnt;

    // Insert the incoming pixel into the next free lane; upper lanes are kept zero.
    always_comb begin
        merged = lanes | (SDP_DATA_W'(pix_data) << (int'(cnt) * PIX_W));
    end

    assign word_rdy = pix_en && (cnt == 3'(PPW - 1));
    assign pending  = (cnt != 3'd0);
    assign word     = word_rdy ? merged : lanes;

    // Lane register and lane counter; cleared at line start, after a full word and on flush.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lanes <= '0;
            cnt   <= 3'd0;
        end else if (clr || flush || word_rdy) begin
            lanes <= '0;
            cnt   <= 3'd0;
        end else if (pix_en) begin
            lanes <= merged;
            cnt   <= cnt + 3'd1;
        end
    end

endmodule

// File: rtl/sdp00_line_writer.sv
// Line writer for the 256x32 sdp00 buffer: packs a pixel line into words and
// writes it into one of two 128-word banks used ping-pong. A finished bank is
// marked full until the reader releases it.
// Handshake: the pixel stream has no backpressure; every pix_vld cycle in FILL
// is consumed. Writes are fire-and-forget single-cycle wr_ce pulses.
module sdp00_line_writer
    import sdp00_line_writer_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  pix_vld,
    input  logic [PIX_W-1:0]      pix_data,
    input  logic                  sol,
    input  logic                  eol,
    input  logic                  rd_release,
    input  logic                  rd_bank,
    input  logic                  clr_err,
    output logic                  wr_ce,
    output logic [SDP_ADDR_W-1:0] wr_addr,
    output logic [SDP_DATA_W-1:0] wr_data,
    output logic                  line_done,
    output logic                  line_bank,
    output logic [7:0]            line_words,
    output logic [1:0]            bank_full,
    output logic                  line_drop,
    output logic                  ovf_err,
    output logic                  seq_err,
    output logic [1:0]            dbg_state
);

    localparam logic [7:0] FULL_IDX = 8'(SDP_BANK_WORDS);

    state_t                state;
    logic                  wr_bank;
    logic [7:0]            word_idx;
    logic                  pix_en;
    logic                  pk_clr;
    logic                  pk_flush;
    logic                  word_rdy;
    logic                  pending;
    logic [SDP_DATA_W-1:0] pk_word;

    // Pixels are accepted only inside a line and only while the bank has room.
    always_comb begin
        pix_en   = (state == ST_FILL) && pix_vld && !sol && (word_idx < FULL_IDX);
        pk_clr   = sol && ((state == ST_IDLE) || (state == ST_FILL));
        pk_flush = (state == ST_FLUSH);
    end

    assign dbg_state = state;

    sdp00_line_writer_pix_pack #(
        .PIX_W (PIX_W)
    ) u_pack (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (pk_clr),
        .pix_en   (pix_en),
        .pix_data (pix_data),
        .flush    (pk_flush),
        .word_rdy (word_rdy),
        .pending  (pending),
        .word     (pk_word)
    );

    // Line FSM with registered write port, bank bookkeeping and sticky errors.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            wr_bank    <= 1'b0;
            word_idx   <= 8'd0;
            wr_ce      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            line_done  <= 1'b0;
            line_bank  <= 1'b0;
            line_words <= 8'd0;
            bank_full  <= 2'b00;
            line_drop  <= 1'b0;
            ovf_err    <= 1'b0;
            seq_err    <= 1'b0;
        end else begin
            wr_ce     <= 1'b0;
            line_done <= 1'b0;
            line_drop <= 1'b0;

            // Clears come first so that a coincident error set wins.
            if (clr_err) begin
                ovf_err <= 1'b0;
                seq_err <= 1'b0;
            end
            // Release before the FLUSH set: a bank being committed stays full.
            if (rd_release) begin
                bank_full[rd_bank] <= 1'b0;
            end

            if (word_rdy) begin
                wr_ce    <= 1'b1;
                wr_addr  <= {wr_bank, word_idx[6:0]};
                wr_data  <= pk_word;
                word_idx <= word_idx + 8'd1;
            end

            case (state)
                ST_IDLE: begin
                    if (sol) begin
                        if (bank_full[wr_bank]) begin
                            line_drop <= 1'b1;
                            state     <= ST_DROP;
                        end else begin
                            word_idx <= 8'd0;
                            state    <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (sol) begin
                        seq_err  <= 1'b1;
                        word_idx <= 8'd0;
                    end else begin
                        if (pix_vld && (word_idx >= FULL_IDX)) begin
                            ovf_err <= 1'b1;
                        end
                        if (eol) begin
                            state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (pending) begin
                        wr_ce   <= 1'b1;
                        wr_addr <= {wr_bank, word_idx[6:0]};
                        wr_data <= pk_word;
                    end
                    line_done          <= 1'b1;
                    line_bank          <= wr_bank;
                    line_words         <= word_idx + {7'd0, pending};
                    bank_full[wr_bank] <= 1'b1;
                    wr_bank            <= ~wr_bank;
                    state              <= ST_IDLE;
                end
                ST_DROP: begin
                    if (eol) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdp00_line_writer.sv
// Bench for sdp00_line_writer (PIX_W=8): directed line scenarios plus random
// lines, with a line-level reference model feeding expected-write/commit queues.
module tb_sdp00_line_writer;
    import sdp00_line_writer_pkg::*;

    localparam int MODE_IDLE = 0;
    localparam int MODE_FILL = 1;
    localparam int MODE_DROP = 2;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_vld = 1'b0;
    logic [7:0]  pix_data = 8'd0;
    logic        sol = 1'b0;
    logic        eol = 1'b0;
    logic        rd_release = 1'b0;
    logic        rd_bank = 1'b0;
    logic        clr_err = 1'b0;
    logic        wr_ce;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        line_done;
    logic        line_bank;
    logic [7:0]  line_words;
    logic [1:0]  bank_full;
    logic        line_drop;
    logic        ovf_err;
    logic        seq_err;
    logic [1:0]  dbg_state;

    sdp00_line_writer #(.PIX_W(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pix_vld    (pix_vld),
        .pix_data   (pix_data),
        .sol        (sol),
        .eol        (eol),
        .rd_release (rd_release),
        .rd_bank    (rd_bank),
        .clr_err    (clr_err),
        .wr_ce      (wr_ce),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .line_done  (line_done),
        .line_bank  (line_bank),
        .line_words (line_words),
        .bank_full  (bank_full),
        .line_drop  (line_drop),
        .ovf_err    (ovf_err),
        .seq_err    (seq_err),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [39:0] exp_wr_q[$];
    logic [8:0]  exp_done_q[$];
    logic        exp_drop_q[$];

    logic        m_bank = 1'b0;
    logic [1:0]  m_full = 2'b00;
    int          m_mode = MODE_IDLE;
    logic [7:0]  line_px[$];
    logic        m_ovf = 1'b0;
    logic        m_seq = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every output event is matched against the head of its expected queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (wr_ce) begin
                if (exp_wr_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL wr_unexpected: got addr %0h data %0h want no write", wr_addr, wr_data);
                end else begin
                    chk("wr", {wr_addr, wr_data}, exp_wr_q.pop_front());
                end
            end
            if (line_done) begin
                if (exp_done_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected: got bank %0d words %0d want none", line_bank, line_words);
                end else begin
                    chk("line_done", {line_bank, line_words}, exp_done_q.pop_front());
                end
            end
            if (line_drop) begin
                total++;
                if (exp_drop_q.size() == 0) begin
                    bad++;
                    $display("FAIL drop_unexpected: got line_drop=1 want 0");
                end else begin
                    void'(exp_drop_q.pop_front());
                end
            end
        end
    end

    // Reference model: a line is a list of pixels; word k holds pixels 4k..4k+3.
    function automatic logic [31:0] pack_word(input int base, input int n);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[8*i +: 8] = line_px[base+i];
        return w;
    endfunction

    task automatic add_pixel(input logic [7:0] d);
        int sz;
        if (line_px.size() >= 4 * 128) begin
            m_ovf = 1'b1;
        end else begin
            line_px.push_back(d);
            sz = line_px.size();
            if (sz % 4 == 0) exp_wr_q.push_back({m_bank, 7'(sz / 4 - 1), pack_word(sz - 4, 4)});
        end
    endtask

    task automatic finish_line();
        int n;
        int rem;
        n = line_px.size();
        rem = n % 4;
        if (rem != 0) exp_wr_q.push_back({m_bank, 7'(n / 4), pack_word(n - rem, rem)});
        exp_done_q.push_back({m_bank, 8'((n + 3) / 4)});
        m_full[m_bank] = 1'b1;
        m_bank = ~m_bank;
        m_mode = MODE_IDLE;
    endtask

    // Driver: apply one cycle of inputs and advance the model by the same cycle.
    task automatic step(input logic s, input logic v, input logic e, input logic [7:0] d,
                        input logic rel, input logic rb, input logic clr);
        sol = s; pix_vld = v; eol = e; pix_data = d;
        rd_release = rel; rd_bank = rb; clr_err = clr;
        if (clr) begin
            m_ovf = 1'b0;
            m_seq = 1'b0;
        end
        if (s) begin
            if (m_mode == MODE_FILL) begin
                m_seq = 1'b1;
                line_px.delete();
            end else if (m_mode == MODE_IDLE) begin
                if (m_full[m_bank]) begin
                    exp_drop_q.push_back(1'b1);
                    m_mode = MODE_DROP;
                end else begin
                    line_px.delete();
                    m_mode = MODE_FILL;
                end
            end
        end else begin
            if (v && m_mode == MODE_FILL) add_pixel(d);
            if (e) begin
                if (m_mode == MODE_FILL) finish_line();
                else if (m_mode == MODE_DROP) m_mode = MODE_IDLE;
            end
        end
        if (rel) m_full[rb] = 1'b0;
        @(posedge clk);
        #1;
        sol = 0; pix_vld = 0; eol = 0; pix_data = 8'd0;
        rd_release = 0; rd_bank = 0; clr_err = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 8'd0, 0, 0, 0);
    endtask

    task automatic release_bank(input logic b);
        step(0, 0, 0, 8'd0, 1, b, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic eol_with;
        logic last;

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {wr_ce, wr_addr, wr_data, line_done, line_bank, line_words,
                              bank_full, line_drop, ovf_err, seq_err}, 64'd0);
        chk("reset_state", dbg_state, ST_IDLE);
        rstn = 1'b1;
        idle(2);

        // 8 pixels, eol on the last: two full words into bank 0
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(0, 1, i == 8, 8'(i), 0, 0, 0);
        idle(3);
        chk("t1_bank_full", bank_full, 2'b01);

        // 5 pixels, separate eol: flush of a partial word, goes to bank 1
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 8'hA0 + 8'(i), 0, 0, 0);
        step(0, 0, 1, 8'd0, 0, 0, 0);
        idle(3);
        chk("t2_bank_full", bank_full, 2'b11);

        // Both banks full: sol with a coincident release still drops
        step(1, 0, 0, 8'd0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, i == 2, 8'h55, 0, 0, 0);
        idle(3);
        chk("t3_bank_full_after_release", bank_full, 2'b10);
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i == 3, 8'hC0 + 8'(i), 0, 0, 0);
        idle(3);
        chk("t3_bank_full_refill", bank_full, 2'b11);
        release_bank(0);
        release_bank(0);
        release_bank(1);
        idle(2);
        chk("t3_bank_full_released", bank_full, 2'b00);

        // 600 pixels: overflow stops at 128 words in bank 1
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 600; i++) step(0, 1, i == 599, 8'($urandom), 0, 0, 0);
        idle(3);
        chk("t4_ovf_err", ovf_err, 1'b1);
        step(0, 0, 0, 8'd0, 0, 0, 1);
        idle(1);
        chk("t4_ovf_clr", ovf_err, 1'b0);
        release_bank(1);
        idle(2);

        // Sequence error: restart mid-line, with clr_err on the same cycle
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 8'hEE, 0, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, i == 3, 8'h11 + 8'(i), 0, 0, 0);
        idle(3);
        chk("t5_seq_err", seq_err, 1'b1);
        step(0, 0, 0, 8'd0, 0, 0, 1);
        idle(1);
        chk("t5_seq_clr", seq_err, 1'b0);
        release_bank(0);
        idle(2);

        // Empty line commits zero words and marks the bank full
        step(1, 0, 0, 8'd0, 0, 0, 0);
        step(0, 0, 1, 8'd0, 0, 0, 0);
        idle(3);
        chk("empty_bank_full", bank_full, 2'b10);
        release_bank(1);
        idle(2);

        // Random lines
        for (int l = 0; l < 40; l++) begin
            if ($urandom_range(0, 1) == 1) release_bank(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) step(0, 0, 0, 8'd0, 0, 0, 1);
            step(1, 0, 0, 8'd0, 0, 0, 0);
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(1, 6);
                for (int i = 0; i < n; i++) step(0, 1, 0, 8'($urandom), 0, 0, 0);
                step(1, 0, 0, 8'd0, 0, 0, 0);
            end
            n = $urandom_range(0, 20);
            eol_with = 1'($urandom_range(0, 1));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                last = (i == n - 1) && eol_with;
                step(0, 1, last, 8'($urandom), 0, 0, 0);
            end
            if (!eol_with || n == 0) step(0, 0, 1, 8'd0, 0, 0, 0);
            idle(3);
            chk("rand_bank_full", bank_full, m_full);
        end
        chk("rand_seq_err", seq_err, m_seq);
        chk("rand_ovf_err", ovf_err, m_ovf);

        // Reset mid-line with a write in flight
        release_bank(0);
        release_bank(1);
        idle(2);
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 1, 0, 8'h77, 0, 0, 0);
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 8'h30 + 8'(i), 0, 0, 0);
        chk("inflight_wr_ce", wr_ce, 1'b1);
        rstn = 1'b0;
        #1;
        chk("async_reset_outputs", {wr_ce, wr_addr, wr_data, line_done, line_bank, line_words,
                                    bank_full, line_drop, ovf_err, seq_err}, 64'd0);
        chk("async_reset_state", dbg_state, ST_IDLE);
        exp_wr_q.delete();
        exp_done_q.delete();
        exp_drop_q.delete();
        line_px.delete();
        m_bank = 1'b0;
        m_full = 2'b00;
        m_mode = MODE_IDLE;
        m_ovf = 1'b0;
        m_seq = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(1);
        step(1, 0, 0, 8'd0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, i == 3, 8'h90 + 8'(i), 0, 0, 0);
        idle(3);
        chk("post_reset_bank_full", bank_full, 2'b01);

        // Final report
        idle(5);
        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);
        chk("drop_queue_drained", exp_drop_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
